mux_n1_stream: RTL and testbench

Parametrised N:1 stream multiplexer that generalises the 4-bit 4:1 combinational mux to CHANNELS inputs of WIDTH bits, adds a registered output with valid/ready flow control, and supports two selection modes: fixed select (software-driven `sel`) and fair round-robin. It sits between multiple producer datapaths and a single consumer, for example a shared writeback or debug port. It provides one-cycle latency and full throughput of one transfer per cycle.

---
 rtl/mux_pkg.sv | 15 +
 rtl/mux_n1_stream_rr_pick.sv | 33 +++
 rtl/mux_n1_stream.sv | 80 ++++++++
 tb/tb_mux_n1_stream.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared definitions for the N:1 stream multiplexer: selection modes and
// the select/grant width derivation.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  // Select/grant width: ceil(log2(n)), never narrower than one bit.
  function automatic int unsigned sw_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n1_stream_rr_pick.sv
// Rotating-priority picker: returns the first asserted request at or after
// ptr, wrapping modulo CHANNELS.
module rr_pick
  import mux_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SW       = sw_of(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SW-1:0]       ptr,
  input  logic                en,
  output logic                found,
  output logic [SW-1:0]       idx
);

  logic [2*CHANNELS-1:0] rot;

  always_comb begin
    // Bit k of rot is req[(ptr + k) mod CHANNELS] for k < CHANNELS (ptr < CHANNELS).
    rot   = {req, req} >> ptr;
    found = 1'b0;
    idx   = '0;
    if (en) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (!found && rot[k]) begin
          found = 1'b1;
          idx   = SW'((32'(ptr) + k) % CHANNELS);
        end
      end
    end
  end

endmodule

// File: rtl/mux_n1_stream.sv
// N:1 stream multiplexer with a registered valid/ready output stage and
// fixed-select or round-robin channel selection.
module mux_n1_stream
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SW       = sw_of(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SW-1:0]             sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SW-1:0]             out_grant
);

  logic                      rr_mode;
  logic                      load_en;
  logic                      rr_found;
  logic [SW-1:0]             rr_idx;
  logic                      fixed_hit;
  logic                      win_found;
  logic [SW-1:0]             win_idx;
  logic [SW-1:0]             ptr;
  logic [CHANNELS-1:0]       valid_sh;
  logic [CHANNELS*WIDTH-1:0] data_sh;

  assign rr_mode = (mode_e'(mode) == MODE_RR);
  assign load_en = !out_valid || out_ready;

  rr_pick #(
    .CHANNELS(CHANNELS),
    .SW      (SW)
  ) u_pick (
    .req  (in_valid),
    .ptr  (ptr),
    .en   (rr_mode),
    .found(rr_found),
    .idx  (rr_idx)
  );

  always_comb begin
    valid_sh  = in_valid >> sel;
    fixed_hit = (32'(sel) < CHANNELS) && valid_sh[0];
    win_found = rr_mode ? rr_found : fixed_hit;
    win_idx   = rr_mode ? rr_idx : sel;
    in_ready  = '0;
    if (!rst && load_en && win_found) begin
      in_ready = CHANNELS'(1) << win_idx;
    end
    data_sh = in_data >> (32'(win_idx) * WIDTH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (win_found) begin
        out_data  <= data_sh[WIDTH-1:0];
        out_grant <= win_idx;
        out_valid <= 1'b1;
        if (rr_mode) begin
          ptr <= (win_idx == SW'(CHANNELS - 1)) ? '0 : win_idx + 1'b1;
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_n1_stream.sv
// Bench for mux_n1_stream: a 4-channel and a 3-channel instance share one
// input stream and are each compared against a per-cycle reference model.
module tb_mux_n1_stream;
  import mux_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] in_data;
  logic [3:0]  in_valid;
  logic        mode;
  logic [1:0]  sel;
  logic        out_ready;

  logic [3:0]  ir4, od4;
  logic        ov4;
  logic [1:0]  og4;
  logic [2:0]  ir3;
  logic [3:0]  od3;
  logic        ov3;
  logic [1:0]  og3;

  mux_n1_stream #(.WIDTH(4), .CHANNELS(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ir4), .mode(mode), .sel(sel), .out_data(od4),
    .out_valid(ov4), .out_ready(out_ready), .out_grant(og4)
  );

  mux_n1_stream #(.WIDTH(4), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .in_data(in_data[11:0]), .in_valid(in_valid[2:0]),
    .in_ready(ir3), .mode(mode), .sel(sel), .out_data(od3),
    .out_valid(ov3), .out_ready(out_ready), .out_grant(og3)
  );

  int passed = 0;
  int checks = 0;

  // Model state per instance: [0] = 4 channels, [1] = 3 channels.
  logic       m_valid [2];
  logic [3:0] m_data  [2];
  int         m_grant [2];
  int         m_ptr   [2];
  logic [3:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [3:0] word_of(input int ch);
    return 4'((in_data >> (ch * 4)) & 16'hF);
  endfunction

  task automatic predict(input int n, input int ptr, input logic mv,
                         output bit win, output int w);
    win = 0;
    w   = 0;
    if (rst || (mv && !out_ready)) return;
    if (mode == 1'b0) begin
      if (int'(sel) < n && in_valid[sel]) begin
        win = 1;
        w   = int'(sel);
      end
    end else begin
      for (int off = 0; off < n; off++) begin
        int c;
        c = (ptr + off) % n;
        if (!win && in_valid[c]) begin
          win = 1;
          w   = c;
        end
      end
    end
  endtask

  task automatic step();
    bit win [2];
    int w   [2];
    int n;
    bit was_rst;
    #1;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 4 : 3;
      predict(n, m_ptr[k], m_valid[k], win[k], w[k]);
    end
    chk("in_ready4", 32'(ir4), win[0] ? (32'd1 << w[0]) : 32'd0);
    chk("in_ready3", 32'(ir3), win[1] ? (32'd1 << w[1]) : 32'd0);
    // Word-level scoreboard on the 4-channel instance: nothing lost or duplicated.
    if (rst) sb_q.delete();
    else begin
      if (ov4 && out_ready) begin
        chk("sb_depth", sb_q.size(), 1);
        if (sb_q.size() > 0) chk("sb_data", 32'(od4), 32'(sb_q.pop_front()));
      end
      if (win[0]) sb_q.push_back(word_of(w[0]));
    end
    was_rst = rst;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 4 : 3;
      if (was_rst) begin
        m_valid[k] = 0; m_data[k] = 0; m_grant[k] = 0; m_ptr[k] = 0;
      end else if (!m_valid[k] || out_ready) begin
        if (win[k]) begin
          m_valid[k] = 1;
          m_data[k]  = word_of(w[k]);
          m_grant[k] = w[k];
          if (mode) m_ptr[k] = (w[k] + 1) % n;
        end else begin
          m_valid[k] = 0;
        end
      end
    end
    chk("out_valid4", 32'(ov4), 32'(m_valid[0]));
    chk("out_valid3", 32'(ov3), 32'(m_valid[1]));
    if (m_valid[0] || was_rst) begin
      chk("out_data4", 32'(od4), 32'(m_data[0]));
      chk("out_grant4", 32'(og4), 32'(m_grant[0]));
    end
    if (m_valid[1] || was_rst) begin
      chk("out_data3", 32'(od3), 32'(m_data[1]));
      chk("out_grant3", 32'(og3), 32'(m_grant[1]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 0; m_data[k] = 0; m_grant[k] = 0; m_ptr[k] = 0;
    end
    rst = 1; in_data = 16'h5A81; in_valid = 4'hF; mode = 1'b1; sel = 2'd0; out_ready = 1;
    step(); step();
    rst = 0;
    step();
    chk("first_rr_grant4", 32'(og4), 32'd0);
    chk("first_rr_grant3", 32'(og3), 32'd0);

    // Fixed select, including sel=3 which is out of range for 3 channels.
    mode = 1'b0; sel = 2'd2;
    repeat (3) step();
    chk("fixed_data_sel2", 32'(od4), 32'hA);
    sel = 2'd3;
    repeat (2) step();
    chk("fixed_data_sel3", 32'(od4), 32'h5);
    chk("fixed_sel3_nogrant3", 32'(ov3), 32'd0);

    // Round robin: all valid, then sparse patterns exercising the wrap.
    mode = 1'b1;
    repeat (8) step();
    in_valid = 4'b1010;
    repeat (4) step();
    in_valid = 4'b0101;
    repeat (4) step();

    // Backpressure: hold word 9 from channel 1 for five cycles.
    mode = 1'b0; sel = 2'd1; in_data = 16'h3C96; in_valid = 4'hF;
    step();
    out_ready = 0; mode = 1'b1;
    repeat (5) step();
    chk("stall_data", 32'(od4), 32'h9);
    chk("stall_grant", 32'(og4), 32'd1);
    out_ready = 1;
    repeat (3) step();

    for (int i = 0; i < 1000; i++) begin
      in_valid  = 4'($urandom);
      in_data   = 16'($urandom);
      mode      = 1'($urandom_range(0, 1));
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Reset while a word is stalled: it must never be delivered.
    mode = 1'b0; sel = 2'd0; in_valid = 4'hF; out_ready = 1;
    step();
    out_ready = 0;
    step();
    rst = 1;
    step();
    rst = 0; out_ready = 1; in_valid = 4'h0;
    step();
    chk("rst_drop_valid4", 32'(ov4), 32'd0);
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
